// File: rtl/lane_sync_pkg.sv
// Shared state encodings, sync-word constants and counter widths for lane_sync_ctrl.
package lane_sync_pkg;

    typedef enum logic [2:0] {
        ST_RST_DEC   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HUNT      = 3'd2,
        ST_VERIFY    = 3'd3,
        ST_ALIGNED   = 3'd4
    } lane_state_e;

    localparam logic [63:0] SYNC_WORD_DEF = 64'h78F678F678F678F6;
    localparam logic [1:0]  HDR_CTRL      = 2'b10;

    localparam int RETRAIN_W   = 8;
    localparam int SYNC_ERR_W  = 16;
    localparam int LOCK_LOSS_W = 8;
    localparam int RST_CTR_W   = 8;
    localparam int MF_CTR_W    = 13;
    localparam int TMR_W       = 17;
    localparam int SYNC_N_W    = 8;

endpackage

// File: rtl/lane_sync_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)
            cnt_q <= '0;
        else if (inc_i && (cnt_q != {WIDTH{1'b1}}))
            cnt_q <= cnt_q + WIDTH'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lane_sync_ctrl.sv
// Lane bring-up/supervision: decoder reset sequencing, lock wait, metaframe sync hunt/verify/track.
// Define LANE_STATS_EN to build the SYNC_ERR_CNT / LOCK_LOSS_CNT statistics counters.
module lane_sync_ctrl
    import lane_sync_pkg::*;
#(
    parameter int          MF_LEN       = 2048,
    parameter logic [63:0] SYNC_WORD    = SYNC_WORD_DEF,
    parameter int          RST_CYCLES   = 8,
    parameter int          LOCK_TIMEOUT = 4096,
    parameter int          GOOD_SYNC_N  = 4,
    parameter int          BAD_SYNC_N   = 4
) (
    input  logic                   USER_CLK,
    input  logic                   SYSTEM_RESET,
    input  logic [63:0]            DEC_DATA,
    input  logic [1:0]             DEC_HEADER,
    input  logic                   DEC_LOCKED,
    output logic                   DEC_RESET,
    output logic                   LANE_ALIGNED,
    output logic                   MF_START,
    output logic                   SYNC_ERR,
    output logic [2:0]             CTRL_STATE,
    output logic [RETRAIN_W-1:0]   RETRAIN_CNT,
    output logic [SYNC_ERR_W-1:0]  SYNC_ERR_CNT,
    output logic [LOCK_LOSS_W-1:0] LOCK_LOSS_CNT
);

    localparam logic [RST_CTR_W-1:0] RST_LAST  = RST_CTR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]     LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]     HUNT_LAST = TMR_W'(2 * MF_LEN - 1);
    localparam logic [MF_CTR_W-1:0]  MF_LAST   = MF_CTR_W'(MF_LEN);
    localparam logic [SYNC_N_W-1:0]  GOOD_LAST = SYNC_N_W'(GOOD_SYNC_N - 1);
    localparam logic [SYNC_N_W-1:0]  BAD_LAST  = SYNC_N_W'(BAD_SYNC_N - 1);

    lane_state_e           state_q;
    logic                  dec_rst_q, aligned_q, mf_start_q, sync_err_q;
    logic [RST_CTR_W-1:0]  rst_ctr_q;
    logic [TMR_W-1:0]      tmr_q;
    logic [MF_CTR_W-1:0]   mf_ctr_q;
    logic [SYNC_N_W-1:0]   good_q, bad_q;

    logic sync_hit, check, retrain_d, sync_err_d;

    assign sync_hit   = (DEC_HEADER == HDR_CTRL) && (DEC_DATA == SYNC_WORD);
    assign check      = (mf_ctr_q == MF_LAST);
    // Lock loss outranks the sync check, so no error is flagged on a check cycle without lock.
    assign sync_err_d = DEC_LOCKED && check && !sync_hit &&
                        (state_q inside {ST_VERIFY, ST_ALIGNED});
    assign retrain_d  = ((state_q == ST_WAIT_LOCK) && !DEC_LOCKED && (tmr_q == LOCK_LAST)) ||
                        ((state_q == ST_HUNT) && DEC_LOCKED && !sync_hit && (tmr_q == HUNT_LAST));

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state_q    <= ST_RST_DEC;
            dec_rst_q  <= 1'b1;
            aligned_q  <= 1'b0;
            mf_start_q <= 1'b0;
            sync_err_q <= 1'b0;
            rst_ctr_q  <= '0;
            tmr_q      <= '0;
            mf_ctr_q   <= '0;
            good_q     <= '0;
            bad_q      <= '0;
        end else begin
            mf_start_q <= 1'b0;
            sync_err_q <= sync_err_d;
            if (retrain_d) begin
                state_q   <= ST_RST_DEC;
                dec_rst_q <= 1'b1;
                rst_ctr_q <= '0;
                tmr_q     <= '0;
            end else if (!DEC_LOCKED && (state_q inside {ST_HUNT, ST_VERIFY, ST_ALIGNED})) begin
                state_q   <= ST_WAIT_LOCK;
                aligned_q <= 1'b0;
                tmr_q     <= '0;
                mf_ctr_q  <= '0;
                good_q    <= '0;
                bad_q     <= '0;
            end else begin
                case (state_q)
                    ST_RST_DEC: begin
                        if (rst_ctr_q == RST_LAST) begin
                            state_q   <= ST_WAIT_LOCK;
                            dec_rst_q <= 1'b0;
                            rst_ctr_q <= '0;
                            tmr_q     <= '0;
                        end else begin
                            rst_ctr_q <= rst_ctr_q + RST_CTR_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (DEC_LOCKED) begin
                            state_q <= ST_HUNT;
                            tmr_q   <= '0;
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                    ST_HUNT: begin
                        if (sync_hit) begin
                            state_q  <= ST_VERIFY;
                            mf_ctr_q <= MF_CTR_W'(1);
                            good_q   <= SYNC_N_W'(1);
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                    ST_VERIFY: begin
                        if (!check) begin
                            mf_ctr_q <= mf_ctr_q + MF_CTR_W'(1);
                        end else if (sync_hit) begin
                            mf_ctr_q <= MF_CTR_W'(1);
                            good_q   <= good_q + SYNC_N_W'(1);
                            if (good_q == GOOD_LAST) begin
                                state_q   <= ST_ALIGNED;
                                aligned_q <= 1'b1;
                                bad_q     <= '0;
                            end
                        end else begin
                            state_q  <= ST_HUNT;
                            mf_ctr_q <= '0;
                            good_q   <= '0;
                            tmr_q    <= '0;
                        end
                    end
                    ST_ALIGNED: begin
                        if (!check) begin
                            mf_ctr_q <= mf_ctr_q + MF_CTR_W'(1);
                        end else begin
                            // Flywheel: the metaframe position is kept even across a missed word.
                            mf_ctr_q <= MF_CTR_W'(1);
                            if (sync_hit) begin
                                mf_start_q <= 1'b1;
                                bad_q      <= '0;
                            end else if (bad_q == BAD_LAST) begin
                                state_q   <= ST_HUNT;
                                aligned_q <= 1'b0;
                                mf_ctr_q  <= '0;
                                good_q    <= '0;
                                bad_q     <= '0;
                                tmr_q     <= '0;
                            end else begin
                                bad_q <= bad_q + SYNC_N_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q   <= ST_RST_DEC;
                        dec_rst_q <= 1'b1;
                        aligned_q <= 1'b0;
                        rst_ctr_q <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.WIDTH(RETRAIN_W)) u_retrain_cnt (
        .clk_i (USER_CLK),
        .rst_i (SYSTEM_RESET),
        .clr_i (1'b0),
        .inc_i (retrain_d),
        .cnt_o (RETRAIN_CNT)
    );

`ifdef LANE_STATS_EN
    sat_counter #(.WIDTH(SYNC_ERR_W)) u_sync_err_cnt (
        .clk_i (USER_CLK),
        .rst_i (SYSTEM_RESET),
        .clr_i (1'b0),
        .inc_i (sync_err_d),
        .cnt_o (SYNC_ERR_CNT)
    );

    sat_counter #(.WIDTH(LOCK_LOSS_W)) u_lock_loss_cnt (
        .clk_i (USER_CLK),
        .rst_i (SYSTEM_RESET),
        .clr_i (1'b0),
        .inc_i (!DEC_LOCKED && (state_q inside {ST_HUNT, ST_VERIFY, ST_ALIGNED})),
        .cnt_o (LOCK_LOSS_CNT)
    );
`else
    assign SYNC_ERR_CNT  = '0;
    assign LOCK_LOSS_CNT = '0;
`endif

    assign DEC_RESET    = dec_rst_q;
    assign LANE_ALIGNED = aligned_q;
    assign MF_START     = mf_start_q;
    assign SYNC_ERR     = sync_err_q;
    assign CTRL_STATE   = state_q;

endmodule

// File: tb/tb_lane_sync_ctrl.sv
// Scoreboard bench for lane_sync_ctrl: expected output events are queued with their cycle and matched by a monitor.
module tb_lane_sync_ctrl;

    localparam int          MF    = 128;
    localparam int          RSTC  = 8;
    localparam int          LTO   = 64;
    localparam logic [63:0] SW    = 64'h78F678F678F678F6;
    localparam int          NEVER = 32'h7fffffff;
    localparam int          MON_START = 3;

    localparam int EV_DR_RISE = 0, EV_DR_FALL = 1, EV_AL_RISE = 2,
                   EV_AL_FALL = 3, EV_MF = 4, EV_SE = 5;

    logic        clk = 1'b0;
    logic        SYSTEM_RESET;
    logic [63:0] DEC_DATA;
    logic [1:0]  DEC_HEADER;
    logic        DEC_LOCKED;
    logic        DEC_RESET, LANE_ALIGNED, MF_START, SYNC_ERR;
    logic [2:0]  CTRL_STATE;
    logic [7:0]  RETRAIN_CNT;
    logic [15:0] SYNC_ERR_CNT;
    logic [7:0]  LOCK_LOSS_CNT;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus plan, read by the driver every cycle.
    int rst_lo = 0, rst_hi = 2;
    int lock_at = NEVER, unlock_at = NEVER;
    int sync_base = NEVER;
    bit sync_on = 1'b1;
    bit corrupt[int];
    bit inject[int];

    typedef struct { int kind; int at; } ev_t;
    ev_t exp_q[$];

    lane_sync_ctrl #(
        .MF_LEN(MF), .SYNC_WORD(SW), .RST_CYCLES(RSTC),
        .LOCK_TIMEOUT(LTO), .GOOD_SYNC_N(4), .BAD_SYNC_N(4)
    ) dut (
        .USER_CLK(clk), .SYSTEM_RESET(SYSTEM_RESET), .DEC_DATA(DEC_DATA),
        .DEC_HEADER(DEC_HEADER), .DEC_LOCKED(DEC_LOCKED), .DEC_RESET(DEC_RESET),
        .LANE_ALIGNED(LANE_ALIGNED), .MF_START(MF_START), .SYNC_ERR(SYNC_ERR),
        .CTRL_STATE(CTRL_STATE), .RETRAIN_CNT(RETRAIN_CNT),
        .SYNC_ERR_CNT(SYNC_ERR_CNT), .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_DR_RISE: return "DEC_RESET_rise";
            EV_DR_FALL: return "DEC_RESET_fall";
            EV_AL_RISE: return "LANE_ALIGNED_rise";
            EV_AL_FALL: return "LANE_ALIGNED_fall";
            EV_MF:      return "MF_START";
            default:    return "SYNC_ERR";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic see(input int k);
        bit found = 1'b0;
        n_cmp++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].kind == k && exp_q[i].at == cyc) begin
                exp_q.delete(i);
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_bad++;
            $display("FAIL event %s: seen at cycle %0d, expected never at this cycle", ev_name(k), cyc);
        end
    endtask

    task automatic drain(input string phase);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s missing %s: never seen, required at cycle %0d", phase,
                         ev_name(exp_q[i].kind), exp_q[i].at);
                exp_q.delete(i);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},    CTRL_STATE, 0);
        chk({tag, "_dec_rst"},  DEC_RESET, 1);
        chk({tag, "_aligned"},  LANE_ALIGNED, 0);
        chk({tag, "_mf_start"}, MF_START, 0);
        chk({tag, "_sync_err"}, SYNC_ERR, 0);
        chk({tag, "_retrain"},  RETRAIN_CNT, 0);
        chk({tag, "_secnt"},    SYNC_ERR_CNT, 0);
        chk({tag, "_llcnt"},    LOCK_LOSS_CNT, 0);
    endtask

    // Driver: one decoder word per cycle, changed just after the rising edge.
    initial begin
        logic [63:0] d;
        int b;
        SYSTEM_RESET = 1'b1;
        DEC_LOCKED   = 1'b0;
        DEC_HEADER   = 2'b01;
        DEC_DATA     = '0;
        forever begin
            @(posedge clk);
            #1;
            SYSTEM_RESET = (cyc >= rst_lo) && (cyc <= rst_hi);
            DEC_LOCKED   = (cyc >= lock_at) && (cyc < unlock_at);
            if (sync_on && cyc >= sync_base && ((cyc - sync_base) % MF) == 0) begin
                if (corrupt.exists(cyc)) begin
                    d = SW;
                    if ($urandom_range(0, 1) == 0) begin
                        DEC_HEADER = 2'b01;
                    end else begin
                        b = $urandom_range(0, 63);
                        d[b] = ~d[b];
                        DEC_HEADER = 2'b10;
                    end
                    DEC_DATA = d;
                end else begin
                    DEC_HEADER = 2'b10;
                    DEC_DATA   = SW;
                end
            end else if (inject.exists(cyc)) begin
                DEC_HEADER = 2'b10;
                DEC_DATA   = SW;
            end else begin
                DEC_HEADER = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                DEC_DATA   = {$urandom(), $urandom()};
            end
        end
    end

    // Monitor: every output event must match a queued expectation at the same cycle.
    initial begin
        logic p_dr, p_al;
        p_dr = 1'b0;
        p_al = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc > MON_START) begin
                if (DEC_RESET && !p_dr)    see(EV_DR_RISE);
                if (!DEC_RESET && p_dr)    see(EV_DR_FALL);
                if (LANE_ALIGNED && !p_al) see(EV_AL_RISE);
                if (!LANE_ALIGNED && p_al) see(EV_AL_FALL);
                if (MF_START !== 1'b0)     see(EV_MF);
                if (SYNC_ERR !== 1'b0)     see(EV_SE);
            end
            if (cyc >= MON_START) begin
                p_dr = DEC_RESET;
                p_al = LANE_ALIGNED;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c, off, rise, fall_last, L, s1, r, nexp;
        logic [63:0] exp_sec, exp_llc;
`ifdef LANE_STATS_EN
        exp_sec = 7;
        exp_llc = 1;
`else
        exp_sec = 0;
        exp_llc = 0;
`endif
        // Bring-up: reset released after word 2, decoder locks 20 cycles after DEC_RESET falls.
        expect_ev(EV_DR_FALL, rst_hi + 1 + RSTC);
        wait_until(MON_START);
        chk_reset_vals("reset");
        lock_at   = rst_hi + 1 + RSTC + 20;
        s0        = lock_at + 1 + $urandom_range(0, 100);
        sync_base = s0;
        off       = $urandom_range(2, MF - 3);
        inject[s0 + 6 * MF + off] = 1'b1;
        for (int k = 8; k <= 10; k++) corrupt[s0 + k * MF] = 1'b1;
        for (int k = 13; k <= 16; k++) corrupt[s0 + k * MF] = 1'b1;
        c = s0 + 22 * MF;
        corrupt[c] = 1'b1;
        unlock_at  = c;

        expect_ev(EV_AL_RISE, s0 + 3 * MF + 1);
        for (int k = 4; k <= 21; k++) begin
            if ((k >= 4 && k <= 7) || k == 11 || k == 12 || k == 21)
                expect_ev(EV_MF, s0 + k * MF + 1);
            if ((k >= 8 && k <= 10) || (k >= 13 && k <= 16))
                expect_ev(EV_SE, s0 + k * MF + 1);
        end
        expect_ev(EV_AL_FALL, s0 + 16 * MF + 1);
        expect_ev(EV_AL_RISE, s0 + 20 * MF + 1);
        expect_ev(EV_AL_FALL, c + 1);

        wait_until(lock_at);
        chk("wait_lock_state", CTRL_STATE, 1);
        wait_until(lock_at + 1);
        chk("hunt_state", CTRL_STATE, 2);
        wait_until(s0 + 3 * MF);
        chk("pre_align", LANE_ALIGNED, 0);
        wait_until(s0 + 3 * MF + 1);
        chk("aligned_state", CTRL_STATE, 4);
        wait_until(s0 + 10 * MF + 2);
        chk("three_bad_still_aligned", LANE_ALIGNED, 1);
        chk("three_bad_state", CTRL_STATE, 4);
        wait_until(s0 + 16 * MF + 1);
        chk("four_bad_hunt", CTRL_STATE, 2);
        wait_until(s0 + 17 * MF + 1);
        chk("rehunt_verify", CTRL_STATE, 3);
        wait_until(c + 1);
        chk("lock_drop_state", CTRL_STATE, 1);
        chk("lock_drop_retrain", RETRAIN_CNT, 0);
        chk("sync_err_cnt", SYNC_ERR_CNT, exp_sec);
        chk("lock_loss_cnt", LOCK_LOSS_CNT, exp_llc);
        drain("align");

        // Lock held low: one retrain per RST_CYCLES + LOCK_TIMEOUT, counter saturates at 255.
        for (int n = 1; n <= 257; n++) begin
            rise = c + 1 + LTO + (n - 1) * (RSTC + LTO);
            expect_ev(EV_DR_RISE, rise);
            expect_ev(EV_DR_FALL, rise + RSTC);
        end
        for (int n = 1; n <= 257; n++) begin
            rise = c + 1 + LTO + (n - 1) * (RSTC + LTO);
            if (n <= 2 || n >= 254) begin
                wait_until(rise);
                nexp = (n > 255) ? 255 : n;
                chk($sformatf("retrain_cnt_%0d", n), RETRAIN_CNT, nexp);
                chk($sformatf("retrain_state_%0d", n), CTRL_STATE, 0);
            end
        end
        fall_last = c + 1 + LTO + 256 * (RSTC + LTO) + RSTC;
        wait_until(fall_last);
        drain("retrain");

        // Lock without any sync word: HUNT gives up after 2*MF_LEN cycles.
        sync_on   = 1'b0;
        L         = fall_last + 5;
        lock_at   = L;
        unlock_at = NEVER;
        expect_ev(EV_DR_RISE, L + 1 + 2 * MF);
        expect_ev(EV_DR_FALL, L + 1 + 2 * MF + RSTC);
        wait_until(L + 1);
        chk("hunt_timeout_hunt", CTRL_STATE, 2);
        wait_until(L + 1 + 2 * MF);
        chk("hunt_timeout_state", CTRL_STATE, 0);
        chk("hunt_timeout_retrain_sat", RETRAIN_CNT, 255);

        // Re-lock with syncs, then reset in the middle of VERIFY.
        s1        = L + 2 + 2 * MF + RSTC + $urandom_range(0, 50);
        sync_base = s1;
        sync_on   = 1'b1;
        wait_until(L + 2 + 2 * MF + RSTC);
        chk("relock_hunt", CTRL_STATE, 2);
        drain("hunt_timeout");
        r         = s1 + MF + 30;
        rst_lo    = r;
        rst_hi    = r;
        unlock_at = r + 1;
        expect_ev(EV_DR_RISE, r + 1);
        expect_ev(EV_DR_FALL, r + 1 + RSTC);
        wait_until(r);
        chk("mid_verify_state", CTRL_STATE, 3);
        wait_until(r + 1);
        chk_reset_vals("mid_verify_reset");
        wait_until(r + RSTC + 4);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
